uart_piso: RTL and testbench
============================

Name: uart_piso

Overview:
- Parallel-in serial-out transmitter core of the UART TX path.
- Builds an 11-bit frame from an 8-bit byte and an externally computed parity bit.
- Shifts the frame out LSB-first, one bit per `baud_clk` rising edge.
- Exposes handshake flags plus internal debug observables: bit counter, frame registers, FSM state, counter-full.

Parameters:
- None. Data width is fixed at 8 and frame width at 11.

Ports:
- `baud_clk`  in  1  Baud-rate clock; all state changes on the rising edge.
- `reset_n`  in  1  Reset. Asynchronous, active-high: 1 = reset. The name is kept for compatibility with existing connections.
- `send`  in  1  Transmit request, level-sensitive; sampled in IDLE.
- `parity_type`  in  2  00 = none, 01 = odd, 10 = even, 11 = none.
- `parity_bit`  in  1  Precomputed parity bit, inserted verbatim when `parity_type` is 01 or 10.
- `data_in`  in  8  Byte to transmit.
- `data_tx`  out  1  Serial line; idle level 1.
- `active_flag`  out  1  High while a frame is being shifted.
- `done_flag`  out  1  One-cycle pulse after the final bit.
- `stop_count`  out  4  Bit counter of the current frame.
- `frame_r`  out  11  Combinational frame assembled from the current inputs.
- `frame_man`  out  11  Registered shift register holding the remaining frame.
- `next_state`  out  1  FSM state: 0 = IDLE, 1 = ACTIVE.
- `count_full`  out  1  Combinational; 1 when `stop_count` equals the frame length N.

Behaviour:
- Frame assembly, `frame_r` (combinational):
  - bit0 = 0 (start); bits8:1 = `data_in`[7:0].
  - Parity modes (01, 10): bit9 = `parity_bit`, bit10 = 1 (stop), N = 11.
  - No-parity modes (00, 11): bit9 = 1 (stop), bit10 = 1 (pad), N = 10.
- Reset (async, while `reset_n` = 1):
  - State IDLE; `data_tx` = 1; `active_flag` = 0; `done_flag` = 0.
  - `stop_count` = 0; `frame_man` = 11'h7FF.
- IDLE, on each edge:
  - `done_flag` <= 0.
  - If `send` = 1: `frame_man` <= `frame_r`; `stop_count` <= 0; N is latched from `parity_type`; state <= ACTIVE; `active_flag` <= 1.
  - `data_tx` stays 1.
- ACTIVE, on each edge with `count_full` = 0:
  - `data_tx` <= `frame_man`[0].
  - `frame_man` <= {1'b1, `frame_man`[10:1]}.
  - `stop_count` <= `stop_count` + 1.
- ACTIVE, on the edge where `count_full` = 1:
  - State <= IDLE; `active_flag` <= 0; `done_flag` <= 1.
  - `data_tx` <= 1; `stop_count` <= 0.
- Latency:
  - Start bit appears on `data_tx` after the first edge following the load edge.
  - The last frame bit is driven for one cycle.
  - `done_flag` is high for exactly one cycle, after edge N+1 counted from the load edge.
  - With `send` held high, back-to-back frames repeat every N+2 cycles: load, N bits, done/idle.
- `data_in`, `parity_type` and `parity_bit` changes mid-frame are ignored; they are captured only at load.
- `send` deasserted mid-frame does not abort the frame.
- Reset asserted mid-frame aborts immediately; the line returns to 1 with no done pulse.
- `stop_count` never exceeds 11. The counter does not wrap.

Decomposition:
- Shared package `uart_pkg`:
  - enum `parity_e` {NOPARITY00 = 2'b00, ODD = 2'b01, EVEN = 2'b10, NOPARITY11 = 2'b11}.
  - enum `piso_state_e` {IDLE, ACTIVE}.
  - Constants FRAME_W = 11 and DATA_W = 8.
- One natural sub-module: `piso_frame_gen` (combinational frame and N builder). The FSM and shifter stay in the top.

Test Plan:
- Reset held for 100 ns, then released with `send` = 0 -> `data_tx` = 1, `active_flag` = 0, `done_flag` = 0, `stop_count` = 0.
- Case 1: `data_in` = 0x4A, `parity_type` = 00, `send` = 1.
  - `frame_r` = 11'b11_01001010_0.
  - `data_tx` sequence: 0, 0,1,0,1,0,0,1,0, 1 (10 bits).
  - `done_flag` pulses once; the next frame loads on the following edge.
- Case 2: 0x4A, `parity_type` = 01, `parity_bit` = 0 -> bits 0, 0,1,0,1,0,0,1,0, 0, 1; `count_full` at `stop_count` = 11.
- Case 3: 0x4A, `parity_type` = 10, `parity_bit` = 1 -> bits 0, 01010010, 1, 1; `active_flag` high for exactly 12 cycles.
- Case 4: 0x5A, `parity_type` = 11 -> bits 0, 0,1,0,1,1,0,1,0, 1; `parity_bit` is ignored.
- Case 5: change `data_in` mid-frame, then assert reset mid-frame.
  - Frame content is unchanged by the data change.
  - On reset, `data_tx` = 1, `active_flag` = 0, `next_state` = 0 immediately, and no `done_flag`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int FRAME_W = 11;
    localparam int DATA_W  = 8;

    // Frame lengths with and without a parity bit
    localparam logic [3:0] LEN_PARITY   = 4'd11;
    localparam logic [3:0] LEN_NOPARITY = 4'd10;

    typedef enum logic [1:0] {
        NOPARITY00 = 2'b00,
        ODD        = 2'b01,
        EVEN       = 2'b10,
        NOPARITY11 = 2'b11
    } parity_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } piso_state_e;

    // True when the selected mode carries a parity bit in the frame
    function automatic logic has_parity(input parity_e mode);
        case (mode)
            ODD, EVEN: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/piso_frame_gen.sv
// Combinational frame builder: start bit, data LSB-first, optional parity,
// stop bit, and the resulting frame length.
module piso_frame_gen
    import uart_pkg::*;
(
    input  logic [DATA_W-1:0]  data_in,
    input  logic [1:0]         parity_type,
    input  logic               parity_bit,
    output logic [FRAME_W-1:0] frame,
    output logic [3:0]         frame_len
);

    // Assemble the frame; no-parity modes put the stop bit at bit 9 and pad bit 10
    always_comb begin
        frame     = {1'b1, 1'b1, data_in, 1'b0};
        frame_len = LEN_NOPARITY;
        if (has_parity(parity_e'(parity_type))) begin
            frame     = {1'b1, parity_bit, data_in, 1'b0};
            frame_len = LEN_PARITY;
        end else begin
            frame     = {1'b1, 1'b1, data_in, 1'b0};
            frame_len = LEN_NOPARITY;
        end
    end

endmodule

// File: rtl/uart_piso.sv
// UART transmit shifter: loads a frame on send, shifts it out LSB-first one
// bit per baud_clk edge, then pulses done_flag and returns to idle.
module uart_piso
    import uart_pkg::*;
(
    input  logic               baud_clk,
    input  logic               reset_n,
    input  logic               send,
    input  logic [1:0]         parity_type,
    input  logic               parity_bit,
    input  logic [DATA_W-1:0]  data_in,
    output logic               data_tx,
    output logic               active_flag,
    output logic               done_flag,
    output logic [3:0]         stop_count,
    output logic [FRAME_W-1:0] frame_r,
    output logic [FRAME_W-1:0] frame_man,
    output logic               next_state,
    output logic               count_full
);

    logic [FRAME_W-1:0] frame_s;
    logic [3:0]         frame_len_s;

    piso_state_e        state_r;
    logic               data_tx_r;
    logic               active_r;
    logic               done_r;
    logic [3:0]         stop_count_r;
    logic [FRAME_W-1:0] frame_man_r;
    logic [3:0]         len_r;
    logic               count_full_s;

    piso_frame_gen u_frame_gen (
        .data_in     (data_in),
        .parity_type (parity_type),
        .parity_bit  (parity_bit),
        .frame       (frame_s),
        .frame_len   (frame_len_s)
    );

    // Counter reaches the frame length latched at load time
    assign count_full_s = (stop_count_r == len_r);

    // Control FSM and shift register; reset (active-high despite the name) aborts any frame
    always_ff @(posedge baud_clk or posedge reset_n) begin
        if (reset_n) begin
            state_r      <= IDLE;
            data_tx_r    <= 1'b1;
            active_r     <= 1'b0;
            done_r       <= 1'b0;
            stop_count_r <= 4'd0;
            frame_man_r  <= 11'h7FF;
            len_r        <= LEN_PARITY;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    data_tx_r <= 1'b1;
                    if (send) begin
                        frame_man_r  <= frame_s;
                        stop_count_r <= 4'd0;
                        len_r        <= frame_len_s;
                        state_r      <= ACTIVE;
                        active_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (count_full_s) begin
                        state_r      <= IDLE;
                        active_r     <= 1'b0;
                        done_r       <= 1'b1;
                        data_tx_r    <= 1'b1;
                        stop_count_r <= 4'd0;
                    end else begin
                        data_tx_r    <= frame_man_r[0];
                        frame_man_r  <= {1'b1, frame_man_r[FRAME_W-1:1]};
                        stop_count_r <= stop_count_r + 4'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    active_r  <= 1'b0;
                    done_r    <= 1'b0;
                    data_tx_r <= 1'b1;
                end
            endcase
        end
    end

    assign data_tx     = data_tx_r;
    assign active_flag = active_r;
    assign done_flag   = done_r;
    assign stop_count  = stop_count_r;
    assign frame_r     = frame_s;
    assign frame_man   = frame_man_r;
    assign next_state  = state_r;
    assign count_full  = count_full_s;

endmodule

// File: tb/tb_uart_piso.sv
// Scoreboard bench for uart_piso: the driver pushes expected frames built
// from the framing rules, a monitor pops and checks them bit by bit.
module tb_uart_piso;

    logic        baud_clk;
    logic        reset_n;
    logic        send;
    logic [1:0]  parity_type;
    logic        parity_bit;
    logic [7:0]  data_in;
    logic        data_tx;
    logic        active_flag;
    logic        done_flag;
    logic [3:0]  stop_count;
    logic [10:0] frame_r;
    logic [10:0] frame_man;
    logic        next_state;
    logic        count_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] frame;
        int          n;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   mon_en   = 1'b0;
    bit   in_frame = 1'b0;
    int   k        = 0;
    int   act_cnt  = 0;

    uart_piso dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .send        (send),
        .parity_type (parity_type),
        .parity_bit  (parity_bit),
        .data_in     (data_in),
        .data_tx     (data_tx),
        .active_flag (active_flag),
        .done_flag   (done_flag),
        .stop_count  (stop_count),
        .frame_r     (frame_r),
        .frame_man   (frame_man),
        .next_state  (next_state),
        .count_full  (count_full)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list the line bits in transmit order, pad with 1s to 11
    function automatic exp_t model(input logic [7:0] d, input logic [1:0] pt, input logic pb);
        exp_t e;
        bit   bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pt == 2'd1 || pt == 2'd2) bits.push_back(pb);
        bits.push_back(1'b1);
        e.n     = bits.size();
        e.frame = 11'h7FF;
        for (int i = 0; i < e.n; i++) e.frame[i] = bits[i];
        return e;
    endfunction

    // Monitor: one step per negedge
    task automatic mon_step();
        if (!in_frame) begin
            chk("idle_done", done_flag, 1'b0);
            if (active_flag) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    cur      = sb.pop_front();
                    in_frame = 1'b1;
                    k        = 0;
                    act_cnt  = 1;
                    chk("load_frame_man", frame_man, cur.frame);
                    chk("load_line", data_tx, 1'b1);
                    chk("load_count", stop_count, 32'd0);
                    chk("load_state", next_state, 1'b1);
                end
            end else begin
                chk("idle_line", data_tx, 1'b1);
            end
        end else begin
            k++;
            if (k <= cur.n) begin
                if (active_flag) act_cnt++;
                chk("bit", data_tx, cur.frame[k-1]);
                chk("bit_count", stop_count, k);
                chk("count_full", count_full, (k == cur.n));
                chk("bit_active", active_flag, 1'b1);
            end else begin
                chk("done_pulse", done_flag, 1'b1);
                chk("done_active", active_flag, 1'b0);
                chk("done_line", data_tx, 1'b1);
                chk("done_count", stop_count, 32'd0);
                chk("done_state", next_state, 1'b0);
                chk("active_len", act_cnt, cur.n + 1);
                in_frame = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge baud_clk);
            if (mon_en) mon_step();
        end
    end

    // Issue one frame; returns just after its done edge
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb, input bit hold);
        exp_t e;
        e = model(d, pt, pb);
        @(negedge baud_clk);
        data_in     = d;
        parity_type = pt;
        parity_bit  = pb;
        send        = 1'b1;
        #1;
        chk("frame_r", frame_r, e.frame);
        sb.push_back(e);
        @(posedge baud_clk);
        #1;
        data_in     = 8'($urandom);
        parity_type = 2'($urandom);
        parity_bit  = 1'($urandom);
        send        = hold;
        repeat (e.n + 1) @(posedge baud_clk);
    endtask

    initial begin
        exp_t e;
        int   n;
        reset_n     = 1'b1;
        send        = 1'b0;
        parity_type = 2'd0;
        parity_bit  = 1'b0;
        data_in     = 8'h00;
        #100;
        reset_n = 1'b0;
        #1;
        chk("rst_line", data_tx, 1'b1);
        chk("rst_active", active_flag, 1'b0);
        chk("rst_done", done_flag, 1'b0);
        chk("rst_count", stop_count, 32'd0);
        chk("rst_state", next_state, 1'b0);
        chk("rst_frame_man", frame_man, 32'h7FF);
        mon_en = 1'b1;

        // Case 1 literal frame
        @(negedge baud_clk);
        data_in     = 8'h4A;
        parity_type = 2'b00;
        #1;
        chk("case1_frame_lit", frame_r, 32'h694);

        // Directed cases, back-to-back with send held high
        send_frame(8'h4A, 2'b00, 1'b1, 1'b1);
        send_frame(8'h4A, 2'b01, 1'b0, 1'b1);
        send_frame(8'h4A, 2'b10, 1'b1, 1'b1);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b1);
        send_frame(8'h5A, 2'b11, 1'b1, 1'b0);

        // Randomized frames with random holds and idle gaps
        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = 1'($urandom);
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), hold);
            if (!hold) begin
                @(negedge baud_clk);
                send = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge baud_clk);
            end
        end
        @(negedge baud_clk);
        send = 1'b0;
        #1;
        repeat (14) @(negedge baud_clk);
        chk("sb_drained", sb.size(), 32'd0);
        chk("mon_idle", in_frame, 1'b0);

        // Case 5: data change mid-frame, then reset mid-frame
        e = model(8'hC3, 2'b01, 1'b1);
        n = e.n;
        @(negedge baud_clk);
        data_in     = 8'hC3;
        parity_type = 2'b01;
        parity_bit  = 1'b1;
        send        = 1'b1;
        sb.push_back(e);
        @(posedge baud_clk);
        #1;
        send    = 1'b0;
        data_in = 8'h3C;
        repeat (5) @(posedge baud_clk);
        @(negedge baud_clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("midrst_line", data_tx, 1'b1);
        chk("midrst_active", active_flag, 1'b0);
        chk("midrst_state", next_state, 1'b0);
        chk("midrst_done", done_flag, 1'b0);
        chk("midrst_count", stop_count, 32'd0);
        repeat (2) @(negedge baud_clk);
        chk("midrst_hold_done", done_flag, 1'b0);
        chk("midrst_bits_seen", in_frame, 1'b1);
        chk("midrst_len", n, 32'd11);
        reset_n  = 1'b0;
        in_frame = 1'b0;
        sb.delete();
        repeat (3) @(negedge baud_clk);
        #1;
        chk("post_rst_done", done_flag, 1'b0);
        chk("post_rst_line", data_tx, 1'b1);
        mon_en = 1'b1;

        // One more frame after reset to confirm normal operation resumes
        send_frame(8'hA5, 2'b10, 1'b0, 1'b0);
        @(negedge baud_clk);
        send = 1'b0;
        repeat (3) @(negedge baud_clk);
        chk("final_drained", sb.size(), 32'd0);
        chk("final_idle", in_frame, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
